// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 (double-dabble) binary-to-BCD converter.
// Converts a WIDTH-bit value into DIGITS packed BCD digits over WIDTH cycles,
// with a leading-zero blank mask and an overflow flag for the display stage.
// Optional macro SIGNED_EN: treat bin_in as two's complement, convert the
// magnitude and report the sign on neg; undefined builds keep neg at 0.
module bin2bcd_seq #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [DIGITS-1:0]     blank,
   output logic                  ovf,
   output logic                  neg
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_CONV = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   sh_q, sh_d;
   logic [BCD_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_acc_q, ovf_acc_d;
   logic               neg_acc_q, neg_acc_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [DIGITS-1:0]  blank_q, blank_d;
   logic               ovf_q, ovf_d;
   logic               neg_q, neg_d;

   logic [BCD_W-1:0]   acc_adj;
   logic [BCD_W-1:0]   acc_step;
   logic [DIGITS-1:0]  blank_new;
   logic               zero_run;
   logic [WIDTH-1:0]   mag;
   logic               in_neg;

   // Input magnitude and sign as seen on the accepting edge
   always_comb begin
`ifdef SIGNED_EN
      in_neg = bin_in[WIDTH-1];
      mag    = in_neg ? ((~bin_in) + WIDTH'(1)) : bin_in;
`else
      in_neg = 1'b0;
      mag    = bin_in;
`endif
   end

   // One double-dabble step: add 3 to digits >= 5, then shift in next bit
   always_comb begin
      acc_adj = acc_q;
      for (int d = 0; d < int'(DIGITS); d++) begin
         if (acc_q[4*d +: 4] >= 4'd5)
            acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
      end
      acc_step = {acc_adj[BCD_W-2:0], sh_q[WIDTH-1]};
   end

   // Leading-zero mask of the stepped accumulator; units digit never blanked
   always_comb begin
      blank_new = '0;
      zero_run  = 1'b1;
      for (int i = int'(DIGITS) - 1; i > 0; i--) begin
         zero_run     = zero_run & (acc_step[4*i +: 4] == 4'd0);
         blank_new[i] = zero_run;
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ovf_acc_d = ovf_acc_q;
      neg_acc_d = neg_acc_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      bcd_d     = bcd_q;
      blank_d   = blank_q;
      ovf_d     = ovf_q;
      neg_d     = neg_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_CONV;
               sh_d      = mag;
               acc_d     = '0;
               cnt_d     = CNT_W'(WIDTH);
               ovf_acc_d = 1'b0;
               neg_acc_d = in_neg;
               busy_d    = 1'b1;
            end
         end
         ST_CONV: begin
            acc_d     = acc_step;
            sh_d      = {sh_q[WIDTH-2:0], 1'b0};
            ovf_acc_d = ovf_acc_q | acc_adj[BCD_W-1];
            cnt_d     = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               bcd_d   = acc_step;
               blank_d = blank_new;
               ovf_d   = ovf_acc_q | acc_adj[BCD_W-1];
               neg_d   = neg_acc_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         sh_q      <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         ovf_acc_q <= 1'b0;
         neg_acc_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bcd_q     <= '0;
         blank_q   <= BLANK_RST;
         ovf_q     <= 1'b0;
         neg_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sh_q      <= sh_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         ovf_acc_q <= ovf_acc_d;
         neg_acc_q <= neg_acc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         bcd_q     <= bcd_d;
         blank_q   <= blank_d;
         ovf_q     <= ovf_d;
         neg_q     <= neg_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign bcd_out = bcd_q;
   assign blank   = blank_q;
   assign ovf     = ovf_q;
   assign neg     = neg_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed testbench for bin2bcd_seq: default 5-digit instance plus a
// 4-digit instance for overflow; signed expectations follow SIGNED_EN.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, start4;
   logic [15:0] bin_in, bin4;
   logic        busy, done, ovf, neg;
   logic [19:0] bcd_out;
   logic [4:0]  blank;
   logic        busy4, done4, ovf4, neg4;
   logic [15:0] bcd4;
   logic [3:0]  blank4;

   int tests = 0;
   int fails = 0;
   int last_n;
   int last_busy;
   int dones;

   always #5 clk = ~clk;

   bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
      .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
      .busy(busy), .done(done), .bcd_out(bcd_out), .blank(blank),
      .ovf(ovf), .neg(neg)
   );

   bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .bin_in(bin4),
      .busy(busy4), .done(done4), .bcd_out(bcd4), .blank(blank4),
      .ovf(ovf4), .neg(neg4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Launch one conversion and wait (bounded) for done; inj>=0 pulses start
   // with bin_in=7 that many cycles into the conversion.
   task automatic conv(input bit sel4, input logic [15:0] v, input int inj);
      int n;
      int nb;
      if (sel4) begin start4 = 1'b1; bin4 = v; end
      else begin start = 1'b1; bin_in = v; end
      @(posedge clk); #1;
      start  = 1'b0;
      start4 = 1'b0;
      n  = 0;
      nb = 0;
      while (!(sel4 ? done4 : done) && n < 40) begin
         if (sel4 ? busy4 : busy) nb++;
         if (n == inj) begin start = 1'b1; bin_in = 16'd7; end
         else start = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      start     = 1'b0;
      last_n    = n;
      last_busy = nb;
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      start4 = 1'b0;
      bin_in = '0;
      bin4   = '0;
      @(posedge clk); @(posedge clk); #1;

      // Reset state
      check("rst_busy",  32'(busy),    32'h0);
      check("rst_done",  32'(done),    32'h0);
      check("rst_bcd",   32'(bcd_out), 32'h0);
      check("rst_blank", 32'(blank),   32'h1e);
      check("rst_ovf",   32'(ovf),     32'h0);
      check("rst_neg",   32'(neg),     32'h0);
      reset = 1'b0;

      // Zero: latency and busy width
      conv(1'b0, 16'd0, -1);
      check("zero_lat",   32'(last_n),    32'd16);
      check("zero_busy",  32'(last_busy), 32'd16);
      check("zero_bcd",   32'(bcd_out),   32'h00000);
      check("zero_blank", 32'(blank),     32'h1e);
      check("zero_ovf",   32'(ovf),       32'h0);
      check("zero_bsy_done", 32'(busy),   32'h0);
      @(posedge clk); #1;
      check("zero_pulse", 32'(done),      32'h0);

      // Max value with an ignored start during CONV
      conv(1'b0, 16'd65535, 5);
      check("max_lat",   32'(last_n),  32'd16);
      check("max_bcd",   32'(bcd_out), 32'h65535);
      check("max_blank", 32'(blank),   32'h00);
      check("max_ovf",   32'(ovf),     32'h0);
      repeat (3) @(posedge clk);
      #1;
      check("max_idle",  32'(busy),    32'h0);
      check("max_hold",  32'(bcd_out), 32'h65535);

      // Back-to-back with start held high
      start  = 1'b1;
      bin_in = 16'd12345;
      @(posedge clk); #1;
      bin_in = 16'd42;
      last_n = 0;
      while (!done && last_n < 40) begin @(posedge clk); #1; last_n++; end
      check("b2b_lat1",  32'(last_n),  32'd16);
      check("b2b_bcd1",  32'(bcd_out), 32'h12345);
      check("b2b_blk1",  32'(blank),   32'h00);
      last_n = 0;
      @(posedge clk); #1; last_n++;
      while (!done && last_n < 40) begin @(posedge clk); #1; last_n++; end
      start = 1'b0;
      check("b2b_gap",   32'(last_n),  32'd17);
      check("b2b_bcd2",  32'(bcd_out), 32'h00042);
      check("b2b_blk2",  32'(blank),   32'h1c);
      @(posedge clk); #1;
      check("b2b_stop",  32'(busy),    32'h0);

      // Reset mid-conversion
      start  = 1'b1;
      bin_in = 16'd9999;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid_busy",  32'(busy),    32'h0);
      check("mid_bcd",   32'(bcd_out), 32'h0);
      check("mid_blank", 32'(blank),   32'h1e);
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      check("mid_nodone", 32'(dones),  32'd0);
      conv(1'b0, 16'd9999, -1);
      check("mid_bcd2",  32'(bcd_out), 32'h09999);
      check("mid_blk2",  32'(blank),   32'h10);

      // Four-digit overflow
      conv(1'b1, 16'd10000, -1);
      check("d4_lat",    32'(last_n),  32'd16);
      check("d4_ovf",    32'(ovf4),    32'h1);
      check("d4_bcd",    32'(bcd4),    32'h0000);
      check("d4_blank",  32'(blank4),  32'he);
      conv(1'b1, 16'd9999, -1);
      check("d4_ovf2",   32'(ovf4),    32'h0);
      check("d4_bcd2",   32'(bcd4),    32'h9999);
      check("d4_blank2", 32'(blank4),  32'h0);

      // Sign handling
      conv(1'b0, 16'hffff, -1);
`ifdef SIGNED_EN
      check("s_ffff_neg", 32'(neg),     32'h1);
      check("s_ffff_bcd", 32'(bcd_out), 32'h00001);
`else
      check("s_ffff_neg", 32'(neg),     32'h0);
      check("s_ffff_bcd", 32'(bcd_out), 32'h65535);
`endif
      conv(1'b0, 16'h8000, -1);
`ifdef SIGNED_EN
      check("s_8000_neg", 32'(neg),     32'h1);
`else
      check("s_8000_neg", 32'(neg),     32'h0);
`endif
      check("s_8000_bcd", 32'(bcd_out), 32'h32768);
      conv(1'b0, 16'h0005, -1);
      check("s_0005_neg", 32'(neg),     32'h0);
      check("s_0005_bcd", 32'(bcd_out), 32'h00005);
      check("s_0005_blk", 32'(blank),   32'h1e);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter (shift-add-3 / double-dabble) between the CPU register outputs and the per-digit seven-segment decoders. Converts one WIDTH-bit register value into DIGITS packed BCD digits over WIDTH clock cycles, using a start/busy/done handshake. Also produces a leading-zero blank mask and an overflow flag so the display stage can show decimal values instead of a single hex nibble.

Parameters:
WIDTH, 16, bit width of the binary input.
DIGITS, 5, number of BCD digits produced (5 covers 0..65535).

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a conversion of bin_in; sampled only in IDLE
bin_in  input  WIDTH  value to convert; sampled on the accepting edge only
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd_out/blank/ovf/neg are updated
bcd_out  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0]
blank  output  DIGITS  bit i=1 means digit i is a leading zero; bit 0 is always 0
ovf  output  1  result did not fit in DIGITS digits
neg  output  1  input was negative (SIGNED_EN only; otherwise 0)

Behaviour:
- Reset (synchronous, active-high), on the next rising edge with reset=1: state=IDLE, busy=0, done=0, bcd_out=0, blank={DIGITS-1{1'b1},1'b0}, ovf=0, neg=0, internal shift/count registers cleared. Reset overrides start and any conversion in progress.
- States: IDLE, CONV.
- IDLE: on an edge with start=1: latch bin_in into the shift register, clear the BCD accumulator and sticky ovf, load count=WIDTH, go to CONV, busy=1. With start=0, remain in IDLE and hold all outputs.
- CONV, per edge:
  - In every accumulator digit >=5, add 3 (4-bit, no carry between digits).
  - Shift {accumulator, shift register} left one bit.
  - If the bit shifted out of the top digit is 1, set sticky ovf.
  - Decrement count.
- On the edge where count goes 1->0:
  - Write the final accumulator to bcd_out.
  - Compute blank: scan from the MSD down; bit i=1 while digit i and every higher digit are 0; digit 0 is never blanked.
  - Publish ovf.
  - done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency: start accepted at edge E0 -> done high in the cycle after edge E0+WIDTH (WIDTH+1 edges, 17 at default). busy is high from E0 until E0+WIDTH.
- start while busy is ignored; bin_in changes during CONV have no effect.
- start high during the done cycle is accepted (state is IDLE), giving back-to-back conversions every WIDTH+1 cycles.
- bcd_out, blank, ovf and neg hold their last published values between done pulses and during a conversion.
- Reset mid-conversion: conversion abandoned, no done pulse, all outputs return to reset values.
- ovf=1: bcd_out holds the low DIGITS digits of the true result (modulo 10^DIGITS); blank is computed on those digits.

Optional Feature:
SIGNED_EN
- Defined:
  - bin_in is two's complement.
  - On acceptance, neg latches bin_in[WIDTH-1] and the shift register loads the magnitude (negated if negative; the most-negative value gives magnitude 2^(WIDTH-1), e.g. 32768).
  - neg is published with done.
- Not defined: bin_in is unsigned, neg is constantly 0, and no negation logic is synthesized.

Test Plan:
- Reset, then start with bin_in=0 -> done 17 cycles after the start edge; bcd_out=0x00000, blank=5'b11110, ovf=0; busy high for exactly 16 cycles before done.
- bin_in=65535 -> bcd_out=0x65535, blank=5'b00000, ovf=0; start pulsed during CONV with bin_in=7 is ignored and the result is unchanged.
- start held high continuously, bin_in=12345 then 42 -> done pulses 17 cycles apart; results 0x12345/blank 00000, then 0x00042/blank 11100.
- Reset asserted 8 cycles into converting 9999 -> no done pulse; outputs return to reset values; a later conversion of 9999 gives 0x09999 with blank 10000.
- DIGITS=4 instance, bin_in=10000 -> ovf=1, bcd_out=0x0000, blank=4'b1110; then bin_in=9999 -> ovf=0, bcd_out=0x9999.
- SIGNED_EN defined, bin_in=16'hFFFF -> neg=1, bcd_out=0x00001; bin_in=16'h8000 -> neg=1, bcd_out=0x32768; bin_in=16'h0005 -> neg=0, bcd_out=0x00005.
